// File: rtl/jzjpcc_pkg.sv
// Shared types and opcode constants for the jzjpcc RV32I pipeline.
package jzjpcc_pkg;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // CLS_LUI is the all-zero encoding so a reset ID/EX register reads as zero.
   typedef enum logic [3:0] {
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
      CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_MISC_MEM, CLS_SYSTEM
   } op_class_t;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/jzjpcc_immediate_gen.sv
// Sign-extended I/S/B/U/J immediates; the opcode bits are not needed here.
module jzjpcc_immediate_gen (
   input  logic [31:7] instr,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/jzjpcc_decode.sv
// jzjpcc decode stage: decode, JAL redirect, load-use stall and the ID/EX register.
// Define JZJPCC_ILLEGAL_INSTR_EN to add illegal-instruction detection and illegal_execute.
module jzjpcc_decode
   import jzjpcc_pkg::*;
#(
   parameter int PC_MAX_B = 13
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [31:0]         instruction_decode,
   input  logic [PC_MAX_B:2]   currentPC_decode,
   input  logic                flushExecute,
   input  logic                stall_execute,
   output logic [4:0]          rs1Address,
   output logic [4:0]          rs2Address,
   input  logic [31:0]         rs1Value,
   input  logic [31:0]         rs2Value,
   output logic                pcCTWriteEnable,
   output logic [PC_MAX_B:2]   controlTransferNewPC,
   output logic                stall_fetch,
   output logic                flush_decode,
   output logic                valid_execute,
   output logic [PC_MAX_B:2]   currentPC_execute,
   output logic [31:0]         rs1Value_execute,
   output logic [31:0]         rs2Value_execute,
   output logic [31:0]         immediate_execute,
   output logic [4:0]          rs1Address_execute,
   output logic [4:0]          rs2Address_execute,
   output logic [4:0]          rdAddress_execute,
   output alu_op_t             aluOp_execute,
   output op_class_t           opClass_execute,
   output logic [2:0]          funct3_execute,
`ifdef JZJPCC_ILLEGAL_INSTR_EN
   output logic                illegal_execute,
`endif
   output logic                writesRd_execute
);

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] imm;
   op_class_t   op_class;
   alu_op_t     alu_op;
   logic        class_writes, reads_rs1, reads_rs2;
   logic        writes_rd, illegal, load_use, bubble;

   assign opcode     = instruction_decode[6:0];
   assign rd         = instruction_decode[11:7];
   assign funct3     = instruction_decode[14:12];
   assign funct7     = instruction_decode[31:25];
   assign rs1Address = instruction_decode[19:15];
   assign rs2Address = instruction_decode[24:20];

   jzjpcc_immediate_gen u_imm (
      .instr (instruction_decode[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j)
   );

   // Unknown opcodes fall through as SYSTEM: no register reads, no writeback.
   always_comb begin
      op_class     = CLS_SYSTEM;
      imm          = '0;
      class_writes = 1'b0;
      reads_rs1    = 1'b0;
      reads_rs2    = 1'b0;
      case (opcode)
         OPC_LUI:      begin op_class = CLS_LUI;      imm = imm_u; class_writes = 1'b1; end
         OPC_AUIPC:    begin op_class = CLS_AUIPC;    imm = imm_u; class_writes = 1'b1; end
         OPC_JAL:      begin op_class = CLS_JAL;      imm = imm_j; class_writes = 1'b1; end
         OPC_JALR:     begin op_class = CLS_JALR;     imm = imm_i; class_writes = 1'b1; reads_rs1 = 1'b1; end
         OPC_BRANCH:   begin op_class = CLS_BRANCH;   imm = imm_b; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OPC_LOAD:     begin op_class = CLS_LOAD;     imm = imm_i; class_writes = 1'b1; reads_rs1 = 1'b1; end
         OPC_STORE:    begin op_class = CLS_STORE;    imm = imm_s; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OPC_OP_IMM:   begin op_class = CLS_OP_IMM;   imm = imm_i; class_writes = 1'b1; reads_rs1 = 1'b1; end
         OPC_OP:       begin op_class = CLS_OP;       class_writes = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
         OPC_MISC_MEM: begin op_class = CLS_MISC_MEM; imm = imm_i; end
         OPC_SYSTEM:   begin op_class = CLS_SYSTEM;   imm = imm_i; end
         default:      begin op_class = CLS_SYSTEM; end
      endcase
   end

   // funct7[5] selects SUB only for OP and SRA for OP/OP_IMM shifts.
   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000: alu_op = (op_class == CLS_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001: alu_op = ALU_SLL;
         3'b010: alu_op = ALU_SLT;
         3'b011: alu_op = ALU_SLTU;
         3'b100: alu_op = ALU_XOR;
         3'b101: alu_op = ((op_class == CLS_OP || op_class == CLS_OP_IMM) && funct7[5]) ? ALU_SRA : ALU_SRL;
         3'b110: alu_op = ALU_OR;
         3'b111: alu_op = ALU_AND;
      endcase
   end

`ifdef JZJPCC_ILLEGAL_INSTR_EN
   // Any opcode with instr[1:0] != 2'b11 misses every constant and lands in default.
   always_comb begin
      illegal = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_SYSTEM: illegal = 1'b0;
         OPC_JAL:      illegal = imm_j[1];
         OPC_JALR:     illegal = (funct3 != 3'b000);
         OPC_BRANCH:   illegal = (funct3[2:1] == 2'b01);
         OPC_LOAD:     illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         OPC_STORE:    illegal = (funct3 > 3'b010);
         OPC_OP_IMM:   illegal = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                                 (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
         OPC_OP:       illegal = !(funct7 == 7'b0000000 ||
                                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         OPC_MISC_MEM: illegal = (funct3[2:1] != 2'b00);
         default:      illegal = 1'b1;
      endcase
   end
`else
   assign illegal = 1'b0;
`endif

   assign writes_rd = class_writes && (rd != 5'd0) && !illegal;

   assign load_use = valid_execute && (opClass_execute == CLS_LOAD) && (rdAddress_execute != 5'd0) &&
                     ((reads_rs1 && rs1Address == rdAddress_execute) ||
                      (reads_rs2 && rs2Address == rdAddress_execute));

   assign stall_fetch          = stall_execute || (!flushExecute && load_use);
   assign pcCTWriteEnable      = (op_class == CLS_JAL) && !flushExecute && !stall_fetch && !illegal;
   assign flush_decode         = pcCTWriteEnable;
   assign controlTransferNewPC = currentPC_decode + imm_j[PC_MAX_B:2];
   assign bubble               = flushExecute || load_use;

   // Bubbles still capture the decoded fields; only valid/writesRd are cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_execute      <= 1'b0;
         writesRd_execute   <= 1'b0;
         currentPC_execute  <= '0;
         rs1Value_execute   <= '0;
         rs2Value_execute   <= '0;
         immediate_execute  <= '0;
         rs1Address_execute <= '0;
         rs2Address_execute <= '0;
         rdAddress_execute  <= '0;
         aluOp_execute      <= ALU_ADD;
         opClass_execute    <= CLS_LUI;
         funct3_execute     <= '0;
`ifdef JZJPCC_ILLEGAL_INSTR_EN
         illegal_execute    <= 1'b0;
`endif
      end else if (!stall_execute) begin
         valid_execute      <= !bubble;
         writesRd_execute   <= writes_rd && !bubble;
         currentPC_execute  <= currentPC_decode;
         rs1Value_execute   <= rs1Value;
         rs2Value_execute   <= rs2Value;
         immediate_execute  <= imm;
         rs1Address_execute <= rs1Address;
         rs2Address_execute <= rs2Address;
         rdAddress_execute  <= rd;
         aluOp_execute      <= alu_op;
         opClass_execute    <= op_class;
         funct3_execute     <= funct3;
`ifdef JZJPCC_ILLEGAL_INSTR_EN
         illegal_execute    <= illegal && !bubble;
`endif
      end
   end

endmodule

// File: doc/jzjpcc_decode.md
# jzjpcc_decode

Decode stage of the jzjpcc five-stage RV32I pipeline. It sits between `jzjpcc_fetch` and execute. It consumes the fetch stage's IF/ID outputs and decodes the instruction. It drives the control-transfer and hazard signals back into fetch: redirect on JAL, stall on load-use. It also owns the ID/EX pipeline register that feeds execute.

## Interface
Parameters:
- `PC_MAX_B`, default 13: top bit of the word-address PC `[PC_MAX_B:2]`. Must match fetch.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction_decode` in 32: IF/ID instruction from fetch.
- `currentPC_decode` in `[PC_MAX_B:2]`: IF/ID PC from fetch.
- `flushExecute` in 1: execute is redirecting. The current decode instruction is wrong-path.
- `stall_execute` in 1: downstream stall. Hold ID/EX.
- `rs1Address`, `rs2Address` out 5: combinational register-file read addresses, from instr[19:15] and instr[24:20].
- `rs1Value`, `rs2Value` in 32: combinational register-file read data.
- `pcCTWriteEnable` out 1: JAL redirect to fetch.
- `controlTransferNewPC` out `[PC_MAX_B:2]`: JAL target.
- `stall_fetch` out 1: freeze PC and IF/ID.
- `flush_decode` out 1: squash the instruction fetch is latching.
- ID/EX outputs, all registered:
  - `valid_execute` 1
  - `currentPC_execute` `[PC_MAX_B:2]`
  - `rs1Value_execute`, `rs2Value_execute` 32
  - `immediate_execute` 32
  - `rs1Address_execute`, `rs2Address_execute`, `rdAddress_execute` 5
  - `aluOp_execute` (`alu_op_t`)
  - `opClass_execute` (`op_class_t`)
  - `funct3_execute` 3
  - `writesRd_execute` 1
  - `illegal_execute` 1 (macro-gated; see Configuration)

## Operation
Decode, all combinational:
- `opcode` is instr[6:0]. Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM (FENCE/FENCE.I treated as NOP), SYSTEM (NOP).
- Immediate formats I/S/B/U/J, sign-extended to 32 bits.
- `writesRd` is 1 only when the class writes rd and rd≠0.
- ALU op comes from funct3 and funct7[5]. funct7[5] is honoured only for OP, and for OP_IMM shifts.

JAL redirect:
- When the instruction is JAL and neither `flushExecute` nor `stall_fetch` is asserted: `pcCTWriteEnable`=1 and `flush_decode`=1 in the same cycle.
- `controlTransferNewPC` = `currentPC_decode` + imm_j[PC_MAX_B:2]. Arithmetic is modulo 2^(PC_MAX_B−1) words and wraps silently.
- imm_j[1] is discarded.

JALR and BRANCH are passed to execute unresolved; execute drives `flushExecute` for those.

Load-use hazard. A hazard exists when all of the following hold:
- `valid_execute`=1
- `opClass_execute`=LOAD
- `rdAddress_execute`≠0
- `rdAddress_execute` equals a source register the current instruction actually reads

Hazard response: `stall_fetch`=1, no redirect, and a bubble (`valid_execute`=0, `writesRd`=0) is loaded into ID/EX.

ID/EX update, in priority order:
1. `reset`: bubble.
2. `stall_execute`: hold all fields, and `stall_fetch`=1.
3. `flushExecute`: bubble. The instruction is dropped; `stall_fetch`=0.
4. Load-use hazard: bubble.
5. Otherwise: load the decoded instruction with `valid_execute`=1.

A bubble leaves PC and data fields don't-care. Only `valid_execute` and `writesRd_execute` are forced to 0.

## Timing
- One-cycle latency: the instruction in IF/ID at edge N appears on ID/EX outputs after edge N+1.
- Redirect, stall and flush outputs are combinational from the same-cycle IF/ID and ID/EX contents. There is no extra latency.
- A JAL costs exactly one bubble, the squashed fall-through.
- Load-use costs exactly one cycle. The hazard clears the next cycle because ID/EX then holds the bubble.
- Reset values: every `valid_execute`/`writesRd_execute`/`illegal_execute` is 0, and the remaining registered fields are 0. Combinational outputs follow from the resulting state with fetch's post-reset IF/ID.
- Reset asserted mid-stall overrides everything at the next edge.

## Configuration
- `JZJPCC_ILLEGAL_INSTR_EN` defined:
  - `illegal_execute` is set for unknown opcodes, an invalid funct3/funct7 combination, or instr[1:0]≠2'b11.
  - It is also set for a JAL whose imm_j[1]=1. In that case no redirect occurs.
  - An illegal instruction never redirects and has `writesRd_execute`=0.
- Undefined:
  - The port and its logic are absent.
  - Unknown encodings decode as NOP.
  - A misaligned JAL redirects using the truncated target.

## Structure
- `jzjpcc_pkg` holds:
  - `alu_op_t` and `op_class_t` enums.
  - Opcode constants.
  - `NOP_INSTR` = 32'h00000013.
- Sub-module `jzjpcc_immediate_gen` is purely combinational: instruction in, 32-bit immediate out for all five formats.
- Hazard and redirect logic stay in `jzjpcc_decode`.

## Test plan
- Reset: hold `reset` for 2 cycles → all `valid_execute`/`writesRd_execute`=0, `pcCTWriteEnable`=0, `stall_fetch`=0.
- JAL: `instruction_decode`=32'h008000EF (jal x1,+8) at `currentPC_decode`=4 → same cycle `pcCTWriteEnable`=1, `flush_decode`=1, `controlTransferNewPC`=6. Next cycle: `valid_execute`=1, `rdAddress_execute`=1.
- Load-use: ID/EX holds lw x5,0(x1); decode holds 32'h00728333 (add x6,x5,x7) → `stall_fetch`=1 for one cycle. Next edge: `valid_execute`=0; the following edge loads the add.
- No false hazard: ID/EX holds a load to x0; the add reads x0 → `stall_fetch`=0.
- Simultaneous: JAL in decode with `flushExecute`=1 → `pcCTWriteEnable`=0 and next `valid_execute`=0. Separately, `stall_execute`=1 for 3 cycles → ID/EX unchanged and `stall_fetch`=1 throughout.
- With `JZJPCC_ILLEGAL_INSTR_EN`: 32'hFFFFFFFF → `illegal_execute`=1, `writesRd_execute`=0, no redirect.
